// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared light codes, state encoding and phase ordering for the traffic-light controller
package tlc_pkg;

    localparam logic [1:0] LC_RED = 2'b00;
    localparam logic [1:0] LC_YEL = 2'b01;
    localparam logic [1:0] LC_GRN = 2'b11;

    localparam int unsigned TLC_DW = 6;

    // State values double as the light code so the output needs no decoder.
    typedef enum logic [1:0] {
        S_RED = LC_RED,
        S_YEL = LC_YEL,
        S_GRN = LC_GRN
    } tlc_state_e;

    function automatic tlc_state_e next_phase(input tlc_state_e s);
        case (s)
            S_RED:   return S_GRN;
            S_GRN:   return S_YEL;
            default: return S_RED;
        endcase
    endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// rtl/tlc_tick_gen.sv - prescaler producing a one-cycle tick every CLK_HZ cycles while enabled
module tlc_tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] pcnt;

    // Cleared while disabled so a resumed phase always gets a full second.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!en || pcnt == LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign tick = en && (pcnt == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - RED/GREEN/YELLOW sequencer with programmable durations; TLC_COUNTDOWN_EN adds remain output
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DW     = TLC_DW,
    parameter int unsigned RED_S  = 5,
    parameter int unsigned GRN_S  = 4,
    parameter int unsigned YEL_S  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          dur_we,
    input  logic [1:0]    dur_sel,
    input  logic [DW-1:0] dur_val,
    output logic [1:0]    light,
    output logic          light_en,
    output logic          phase_done
`ifdef TLC_COUNTDOWN_EN
    ,
    output logic [DW-1:0] remain
`endif
);

    tlc_state_e    state, state_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] dur_red, dur_grn, dur_yel;
    logic [DW-1:0] load_val;
    logic          phase_done_nxt;
    logic          tick;

    tlc_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .tick  (tick)
    );

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        phase_done_nxt = 1'b0;
        load_val       = dur_red;
        if (tick) begin
            if (cnt > DW'(1)) begin
                cnt_nxt = cnt - DW'(1);
            end else begin
                state_nxt      = next_phase(state);
                phase_done_nxt = 1'b1;
                case (state_nxt)
                    S_GRN:   load_val = dur_grn;
                    S_YEL:   load_val = dur_yel;
                    default: load_val = dur_red;
                endcase
                // A write landing on the entry edge wins over the stored value.
                if (dur_we && dur_sel == state_nxt) begin
                    load_val = dur_val;
                end
                cnt_nxt = load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_RED;
            cnt        <= DW'(RED_S);
            light_en   <= 1'b0;
            phase_done <= 1'b0;
            dur_red    <= DW'(RED_S);
            dur_grn    <= DW'(GRN_S);
            dur_yel    <= DW'(YEL_S);
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            light_en   <= run;
            phase_done <= phase_done_nxt;
            if (dur_we) begin
                case (dur_sel)
                    LC_RED:  dur_red <= dur_val;
                    LC_YEL:  dur_yel <= dur_val;
                    LC_GRN:  dur_grn <= dur_val;
                    default: ;
                endcase
            end
        end
    end

    assign light = state;

`ifdef TLC_COUNTDOWN_EN
    assign remain = cnt;
`endif

endmodule
